// File: rtl/lfsr_core_if.sv
// lfsr_core request/result bundle.
// master drives in_valid/data_in/state_in; slave returns out_valid/data_out/state_out.
interface lfsr_core_if #(
  parameter int LFSR_WIDTH = 31,
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic [LFSR_WIDTH-1:0] state_in;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic [LFSR_WIDTH-1:0] state_out;

  modport master (
    output in_valid, data_in, state_in,
    input  out_valid, data_out, state_out
  );

  modport slave (
    input  in_valid, data_in, state_in,
    output out_valid, data_out, state_out
  );
endinterface

// File: rtl/lfsr_core.sv
// LFSR engine: DATA_WIDTH Fibonacci/Galois steps per clock, registered result.
// Ports: clk, rst (sync, active-high), bus (lfsr_core_if.slave).
module lfsr_core #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter int                    LFSR_FEED_FORWARD = 0,
  parameter int                    REVERSE           = 0,
  parameter int                    DATA_WIDTH        = 8,
  parameter string                 STYLE             = "AUTO"
) (
  input  logic        clk,
  input  logic        rst,
  lfsr_core_if.slave  bus
);

  localparam int W = LFSR_WIDTH;
  localparam int D = DATA_WIDTH;
  localparam int T = W + D;

  localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");
  localparam bit FIB    = (LFSR_CONFIG == "FIBONACCI");
  localparam bit FF     = (LFSR_FEED_FORWARD != 0);
  localparam bit REV    = (REVERSE != 0);

  generate
    if (!GALOIS && !FIB) begin : g_bad_config
      $error("lfsr_core: LFSR_CONFIG must be FIBONACCI or GALOIS");
    end
    if (W < 2 || D < 1) begin : g_bad_width
      $error("lfsr_core: LFSR_WIDTH >= 2 and DATA_WIDTH >= 1");
    end
  endgenerate

  // Symbolic run of the steps: each bit is tracked as the set of
  // input bits ({data, state}) that XOR into it.
  function automatic logic [T-1:0][T-1:0] build_masks();
    logic [T-1:0][T-1:0] m;
    logic [W-1:0][T-1:0] s;
    logic [D-1:0][T-1:0] o;
    logic [T-1:0]        b;
    logic [T-1:0]        fb;
    logic [T-1:0]        nb;
    s = '0;
    o = '0;
    for (int i = 0; i < W; i++) s[i][i] = 1'b1;
    for (int k = D - 1; k >= 0; k--) begin
      b = '0;
      b[W+k] = 1'b1;
      fb = s[W-1] ^ b;
      if (!GALOIS) begin
        for (int j = 1; j < W; j++)
          if (LFSR_POLY[j]) fb ^= s[j-1];
      end
      nb = FF ? b : fb;
      for (int i = W - 1; i >= 1; i--) s[i] = s[i-1];
      s[0] = nb;
      if (GALOIS) begin
        for (int j = 1; j < W; j++)
          if (LFSR_POLY[j]) s[j] ^= nb;
      end
      for (int i = D - 1; i >= 1; i--) o[i] = o[i-1];
      o[0] = fb;
    end
    m = '0;
    for (int i = 0; i < W; i++) m[i] = s[i];
    for (int i = 0; i < D; i++) m[W+i] = o[i];
    return m;
  endfunction

  logic [W-1:0] s_in;
  logic [D-1:0] d_in;
  logic [W-1:0] s_nx;
  logic [D-1:0] d_nx;
  logic [W-1:0] s_res;
  logic [D-1:0] d_res;

  // Reflected mode swaps bit order on both sides of the core.
  for (genvar i = 0; i < W; i++) begin : g_s_rev
    assign s_in[i]  = REV ? bus.state_in[W-1-i] : bus.state_in[i];
    assign s_res[i] = REV ? s_nx[W-1-i] : s_nx[i];
  end

  for (genvar i = 0; i < D; i++) begin : g_d_rev
    assign d_in[i]  = REV ? bus.data_in[D-1-i] : bus.data_in[i];
    assign d_res[i] = REV ? d_nx[D-1-i] : d_nx[i];
  end

  generate
    if (STYLE == "LOOP") begin : g_loop
      logic [W-1:0] ls;
      logic [D-1:0] lo;
      logic         lb;
      logic         lfb;
      logic         lnb;

      always_comb begin
        ls  = s_in;
        lo  = '0;
        lb  = 1'b0;
        lfb = 1'b0;
        lnb = 1'b0;
        for (int k = D - 1; k >= 0; k--) begin
          lb  = d_in[k];
          lfb = ls[W-1] ^ lb;
          if (!GALOIS) begin
            for (int j = 1; j < W; j++)
              if (LFSR_POLY[j]) lfb ^= ls[j-1];
          end
          lnb = FF ? lb : lfb;
          ls  = ls << 1;
          ls[0] = lnb;
          if (GALOIS) begin
            for (int j = 1; j < W; j++)
              if (LFSR_POLY[j]) ls[j] ^= lnb;
          end
          lo    = lo << 1;
          lo[0] = lfb;
        end
        s_nx = ls;
        d_nx = lo;
      end
    end else if (STYLE == "REDUCTION" || STYLE == "AUTO") begin : g_red
      localparam logic [T-1:0][T-1:0] MASKS = build_masks();
      logic [T-1:0] vec;

      assign vec = {d_in, s_in};

      for (genvar i = 0; i < W; i++) begin : g_s
        assign s_nx[i] = ^(MASKS[i] & vec);
      end
      for (genvar i = 0; i < D; i++) begin : g_d
        assign d_nx[i] = ^(MASKS[W+i] & vec);
      end
    end else begin : g_bad_style
      $error("lfsr_core: STYLE must be LOOP, REDUCTION or AUTO");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.state_out <= '0;
      bus.data_out  <= '0;
    end else if (bus.in_valid) begin
      bus.out_valid <= 1'b1;
      bus.state_out <= s_res;
      bus.data_out  <= d_res;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_core.sv
// Self-checking bench for lfsr_core: CRC-8, PRBS7, reflected CRC-32,
// scrambler/descrambler pair, reset and valid behaviour.
module tb_lfsr_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   err = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] s;
    logic [63:0] o;
  } res_t;

  function automatic logic [63:0] rev_bits(logic [63:0] x, int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = x[n-1-i];
    return r;
  endfunction

  // Word-level reference: one step per data bit, MSB first.
  function automatic res_t lfsr_ref(int w, logic [63:0] poly, bit gal,
                                    bit ff, bit rv, int dw,
                                    logic [63:0] s0, logic [63:0] d0);
    logic [63:0] m = (64'd1 << w) - 64'd1;
    logic [63:0] s = s0 & m;
    logic [63:0] d = d0;
    logic [63:0] o = '0;
    logic b, fb, nb;
    res_t r;
    if (rv) begin
      s = rev_bits(s, w);
      d = rev_bits(d, dw);
    end
    for (int k = dw - 1; k >= 0; k--) begin
      b  = d[k];
      fb = s[w-1] ^ b;
      if (!gal) fb = fb ^ (^(s & (poly >> 1) & (m >> 1)));
      nb = ff ? b : fb;
      s  = (s << 1) & m;
      if (gal) begin
        if (nb) s = s ^ ((poly & m & ~64'd1) | 64'd1);
      end else begin
        s = s | {63'd0, nb};
      end
      o = (o << 1) | {63'd0, fb};
    end
    if (rv) begin
      s = rev_bits(s, w);
      o = rev_bits(o, dw);
    end
    r.s = s;
    r.o = o;
    return r;
  endfunction

  lfsr_core_if #(.LFSR_WIDTH(8),  .DATA_WIDTH(8))  b8  ();
  lfsr_core_if #(.LFSR_WIDTH(8),  .DATA_WIDTH(8))  b8l ();
  lfsr_core_if #(.LFSR_WIDTH(7),  .DATA_WIDTH(1))  bp  ();
  lfsr_core_if #(.LFSR_WIDTH(32), .DATA_WIDTH(32)) b32 ();
  lfsr_core_if #(.LFSR_WIDTH(7),  .DATA_WIDTH(8))  bsc ();
  lfsr_core_if #(.LFSR_WIDTH(7),  .DATA_WIDTH(8))  bds ();

  lfsr_core #(.LFSR_WIDTH(8), .LFSR_POLY(8'h07), .LFSR_CONFIG("GALOIS"),
    .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(8), .STYLE("REDUCTION"))
    u_crc8 (.clk(clk), .rst(rst), .bus(b8));

  lfsr_core #(.LFSR_WIDTH(8), .LFSR_POLY(8'h07), .LFSR_CONFIG("GALOIS"),
    .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(8), .STYLE("LOOP"))
    u_crc8l (.clk(clk), .rst(rst), .bus(b8l));

  lfsr_core #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
    .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(1), .STYLE("AUTO"))
    u_prbs (.clk(clk), .rst(rst), .bus(bp));

  lfsr_core #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7),
    .LFSR_CONFIG("GALOIS"), .LFSR_FEED_FORWARD(0), .REVERSE(1),
    .DATA_WIDTH(32), .STYLE("AUTO"))
    u_crc32 (.clk(clk), .rst(rst), .bus(b32));

  lfsr_core #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
    .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(8), .STYLE("LOOP"))
    u_scr (.clk(clk), .rst(rst), .bus(bsc));

  lfsr_core #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
    .LFSR_FEED_FORWARD(1), .REVERSE(0), .DATA_WIDTH(8), .STYLE("REDUCTION"))
    u_dscr (.clk(clk), .rst(rst), .bus(bds));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b8.in_valid  = 1'b0;
    b8l.in_valid = 1'b0;
    bp.in_valid  = 1'b0;
    b32.in_valid = 1'b0;
    bsc.in_valid = 1'b0;
    bds.in_valid = 1'b0;
  endtask

  task automatic drive8(logic v, logic [7:0] s, logic [7:0] d);
    b8.in_valid  = v;
    b8.state_in  = s;
    b8.data_in   = d;
    b8l.in_valid = v;
    b8l.state_in = s;
    b8l.data_in  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive8(1'b1, 8'hA5, 8'h3C);
    bp.in_valid  = 1'b1;
    bp.state_in  = 7'h7F;
    bp.data_in   = 1'b1;
    b32.in_valid = 1'b1;
    b32.state_in = 32'hFFFFFFFF;
    b32.data_in  = $urandom;
    bsc.in_valid = 1'b1;
    bsc.state_in = 7'h55;
    bsc.data_in  = 8'hF0;
    bds.in_valid = 1'b1;
    bds.state_in = 7'h2A;
    bds.data_in  = 8'h0F;
    step();
    step();
    vec++;
    if ({b8.out_valid, b8.state_out, b8.data_out} !== 17'd0) begin
      err++;
      $display("FAIL reset_crc8 got %h exp 0",
               {b8.out_valid, b8.state_out, b8.data_out});
    end
    vec++;
    if ({b8l.out_valid, b8l.state_out, b8l.data_out} !== 17'd0) begin
      err++;
      $display("FAIL reset_crc8_loop got %h exp 0",
               {b8l.out_valid, b8l.state_out, b8l.data_out});
    end
    vec++;
    if ({bp.out_valid, bp.state_out, bp.data_out} !== 9'd0) begin
      err++;
      $display("FAIL reset_prbs got %h exp 0",
               {bp.out_valid, bp.state_out, bp.data_out});
    end
    vec++;
    if ({b32.out_valid, b32.state_out, b32.data_out} !== 65'd0) begin
      err++;
      $display("FAIL reset_crc32 got %h exp 0",
               {b32.out_valid, b32.state_out, b32.data_out});
    end
    vec++;
    if ({bsc.out_valid, bsc.state_out, bsc.data_out,
         bds.out_valid, bds.state_out, bds.data_out} !== 32'd0) begin
      err++;
      $display("FAIL reset_scr got %h exp 0",
               {bsc.out_valid, bsc.state_out, bsc.data_out,
                bds.out_valid, bds.state_out, bds.data_out});
    end
    idle_all();
    rst = 1'b0;
    step();
  endtask

  task automatic test_crc8_table();
    logic [7:0] din [2];
    logic [7:0] es  [2];
    logic [7:0] eo  [2];
    din[0] = 8'h01; es[0] = 8'h07; eo[0] = 8'h01;
    din[1] = 8'h80; es[1] = 8'h89; eo[1] = 8'h83;
    for (int i = 0; i < 2; i++) begin
      drive8(1'b1, 8'h00, din[i]);
      step();
      vec++;
      if ({b8.out_valid, b8.state_out, b8.data_out} !==
          {1'b1, es[i], eo[i]}) begin
        err++;
        $display("FAIL crc8_table[%0d] got %h exp %h", i,
                 {b8.out_valid, b8.state_out, b8.data_out},
                 {1'b1, es[i], eo[i]});
      end
      vec++;
      if ({b8l.out_valid, b8l.state_out, b8l.data_out} !==
          {1'b1, es[i], eo[i]}) begin
        err++;
        $display("FAIL crc8_table_loop[%0d] got %h exp %h", i,
                 {b8l.out_valid, b8l.state_out, b8l.data_out},
                 {1'b1, es[i], eo[i]});
      end
    end
    drive8(1'b0, 8'h00, 8'h00);
    step();
  endtask

  task automatic test_prbs7();
    logic [6:0] s = 7'h7F;
    logic       d;
    res_t       r;
    bp.in_valid = 1'b1;
    bp.state_in = 7'h7F;
    bp.data_in  = 1'b0;
    step();
    vec++;
    if ({bp.out_valid, bp.state_out, bp.data_out} !== {1'b1, 7'h7E, 1'b0}) begin
      err++;
      $display("FAIL prbs7_first got %h exp %h",
               {bp.out_valid, bp.state_out, bp.data_out}, {1'b1, 7'h7E, 1'b0});
    end
    for (int i = 0; i < 24; i++) begin
      d = 1'($urandom_range(0, 1));
      bp.state_in = s;
      bp.data_in  = d;
      r = lfsr_ref(7, 64'h41, 1'b0, 1'b0, 1'b0, 1, {57'd0, s}, {63'd0, d});
      step();
      vec++;
      if ({bp.state_out, bp.data_out} !== {r.s[6:0], r.o[0]}) begin
        err++;
        $display("FAIL prbs7_chain[%0d] got %h exp %h", i,
                 {bp.state_out, bp.data_out}, {r.s[6:0], r.o[0]});
      end
      s = r.s[6:0];
    end
    bp.in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] s, d;
    res_t       r;
    for (int i = 0; i < 64; i++) begin
      s = 8'($urandom);
      d = 8'($urandom);
      drive8(1'b1, s, d);
      r = lfsr_ref(8, 64'h07, 1'b1, 1'b0, 1'b0, 8, {56'd0, s}, {56'd0, d});
      step();
      vec++;
      if ({b8.out_valid, b8.state_out, b8.data_out} !==
          {1'b1, r.s[7:0], r.o[7:0]}) begin
        err++;
        $display("FAIL b2b_crc8[%0d] got %h exp %h", i,
                 {b8.out_valid, b8.state_out, b8.data_out},
                 {1'b1, r.s[7:0], r.o[7:0]});
      end
      vec++;
      if ({b8l.out_valid, b8l.state_out, b8l.data_out} !==
          {1'b1, r.s[7:0], r.o[7:0]}) begin
        err++;
        $display("FAIL b2b_crc8_loop[%0d] got %h exp %h", i,
                 {b8l.out_valid, b8l.state_out, b8l.data_out},
                 {1'b1, r.s[7:0], r.o[7:0]});
      end
    end
    drive8(1'b0, 8'h00, 8'h00);
    step();
  endtask

  task automatic test_crc32_reflect();
    logic [31:0] d;
    logic [63:0] es, eo;
    res_t        r;
    for (int i = 0; i < 32; i++) begin
      d = $urandom;
      b32.in_valid = 1'b1;
      b32.state_in = 32'hFFFFFFFF;
      b32.data_in  = d;
      r  = lfsr_ref(32, 64'h04C11DB7, 1'b1, 1'b0, 1'b0, 32,
                    rev_bits(64'hFFFFFFFF, 32), rev_bits({32'd0, d}, 32));
      es = rev_bits(r.s, 32);
      eo = rev_bits(r.o, 32);
      step();
      vec++;
      if ({b32.out_valid, b32.state_out, b32.data_out} !==
          {1'b1, es[31:0], eo[31:0]}) begin
        err++;
        $display("FAIL crc32_reflect[%0d] got %h exp %h", i,
                 {b32.out_valid, b32.state_out, b32.data_out},
                 {1'b1, es[31:0], eo[31:0]});
      end
    end
    b32.in_valid = 1'b0;
    step();
  endtask

  task automatic test_linearity();
    logic [31:0] s1, s2, d1, d2;
    res_t        r1, r2;
    logic [31:0] es, eo;
    for (int i = 0; i < 1000; i++) begin
      s1 = $urandom;
      s2 = $urandom;
      d1 = $urandom;
      d2 = $urandom;
      r1 = lfsr_ref(32, 64'h04C11DB7, 1'b1, 1'b0, 1'b1, 32,
                    {32'd0, s1}, {32'd0, d1});
      r2 = lfsr_ref(32, 64'h04C11DB7, 1'b1, 1'b0, 1'b1, 32,
                    {32'd0, s2}, {32'd0, d2});
      es = r1.s[31:0] ^ r2.s[31:0];
      eo = r1.o[31:0] ^ r2.o[31:0];
      b32.in_valid = 1'b1;
      b32.state_in = s1 ^ s2;
      b32.data_in  = d1 ^ d2;
      step();
      vec++;
      if ({b32.state_out, b32.data_out} !== {es, eo}) begin
        err++;
        $display("FAIL crc32_linear[%0d] got %h exp %h", i,
                 {b32.state_out, b32.data_out}, {es, eo});
      end
    end
    b32.in_valid = 1'b0;
    step();
  endtask

  task automatic test_scrambler();
    logic [6:0] ss, ds;
    logic [7:0] d, sc;
    res_t       rs, rd;
    ss = 7'($urandom);
    ds = 7'($urandom);
    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom);
      rs = lfsr_ref(7, 64'h41, 1'b0, 1'b0, 1'b0, 8, {57'd0, ss}, {56'd0, d});
      bsc.in_valid = 1'b1;
      bsc.state_in = ss;
      bsc.data_in  = d;
      step();
      bsc.in_valid = 1'b0;
      vec++;
      if ({bsc.state_out, bsc.data_out} !== {rs.s[6:0], rs.o[7:0]}) begin
        err++;
        $display("FAIL scrambler[%0d] got %h exp %h", i,
                 {bsc.state_out, bsc.data_out}, {rs.s[6:0], rs.o[7:0]});
      end
      sc = rs.o[7:0];
      ss = rs.s[6:0];
      rd = lfsr_ref(7, 64'h41, 1'b0, 1'b1, 1'b0, 8, {57'd0, ds}, {56'd0, sc});
      bds.in_valid = 1'b1;
      bds.state_in = ds;
      bds.data_in  = sc;
      step();
      bds.in_valid = 1'b0;
      vec++;
      if ({bds.state_out, bds.data_out} !== {rd.s[6:0], rd.o[7:0]}) begin
        err++;
        $display("FAIL descrambler[%0d] got %h exp %h", i,
                 {bds.state_out, bds.data_out}, {rd.s[6:0], rd.o[7:0]});
      end
      if (i > 0) begin
        vec++;
        if (bds.data_out !== d) begin
          err++;
          $display("FAIL descramble_recover[%0d] got %h exp %h", i,
                   bds.data_out, d);
        end
      end
      ds = rd.s[6:0];
    end
    step();
  endtask

  task automatic test_reset_midstream();
    logic [7:0] s, d;
    res_t       r;
    int         pulses = 0;
    for (int i = 0; i < 3; i++) begin
      drive8(1'b1, 8'($urandom), 8'($urandom));
      step();
    end
    rst = 1'b1;
    drive8(1'b1, 8'hFF, 8'hFF);
    step();
    vec++;
    if ({b8.out_valid, b8.state_out, b8.data_out} !== 17'd0) begin
      err++;
      $display("FAIL midstream_reset got %h exp 0",
               {b8.out_valid, b8.state_out, b8.data_out});
    end
    rst = 1'b0;
    drive8(1'b0, 8'h00, 8'h00);
    step();
    vec++;
    if ({b8.out_valid, b8.state_out, b8.data_out} !== 17'd0) begin
      err++;
      $display("FAIL post_reset_idle got %h exp 0",
               {b8.out_valid, b8.state_out, b8.data_out});
    end
    s = 8'($urandom);
    d = 8'($urandom) | 8'h01;
    r = lfsr_ref(8, 64'h07, 1'b1, 1'b0, 1'b0, 8, {56'd0, s}, {56'd0, d});
    drive8(1'b1, s, d);
    step();
    drive8(1'b0, 8'h00, 8'h00);
    if (b8.out_valid === 1'b1) pulses++;
    vec++;
    if ({b8.out_valid, b8.state_out, b8.data_out} !==
        {1'b1, r.s[7:0], r.o[7:0]}) begin
      err++;
      $display("FAIL pulse_result got %h exp %h",
               {b8.out_valid, b8.state_out, b8.data_out},
               {1'b1, r.s[7:0], r.o[7:0]});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (b8.out_valid === 1'b1) pulses++;
      vec++;
      if ({b8.out_valid, b8.state_out, b8.data_out} !==
          {1'b0, r.s[7:0], r.o[7:0]}) begin
        err++;
        $display("FAIL pulse_hold[%0d] got %h exp %h", i,
                 {b8.out_valid, b8.state_out, b8.data_out},
                 {1'b0, r.s[7:0], r.o[7:0]});
      end
    end
    vec++;
    if (pulses != 1) begin
      err++;
      $display("FAIL pulse_count got %0d exp 1", pulses);
    end
  endtask

  initial begin
    idle_all();
    drive8(1'b0, 8'h00, 8'h00);
    bp.state_in  = '0;
    bp.data_in   = '0;
    b32.state_in = '0;
    b32.data_in  = '0;
    bsc.state_in = '0;
    bsc.data_in  = '0;
    bds.state_in = '0;
    bds.data_in  = '0;
    #1;
    test_reset();
    test_crc8_table();
    test_prbs7();
    test_back_to_back();
    test_crc32_reflect();
    test_linearity();
    test_scrambler();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
